// File: rtl/tick_bcd_counter_pkg.sv
// Shared constants and helpers for the tick-driven BCD counter and its display decoders.
package tick_bcd_counter_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    typedef struct packed {
        logic             carry;
        logic [BCD_W-1:0] digit;
    } bcd_step_t;

    // One BCD digit step; carry flags 9->0 going up or 0->9 going down
    function automatic bcd_step_t bcd_step(input logic [BCD_W-1:0] digit, input logic up);
        bcd_step_t r;
        r.carry = 1'b0;
        r.digit = digit;
        if (up) begin
            if (digit >= BCD_W'(9)) begin
                r.carry = 1'b1;
                r.digit = '0;
            end else begin
                r.digit = digit + BCD_W'(1);
            end
        end else begin
            if (digit == '0) begin
                r.carry = 1'b1;
                r.digit = BCD_W'(9);
            end else begin
                r.digit = digit - BCD_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes blank the display.
module seg7_decode
    import tick_bcd_counter_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_OFF;
        case (i_digit)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Resynchronises the slow divider output, turns its rising edges into ticks and
// drives a two-digit BCD modulo counter with seven-segment outputs.
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter int unsigned MODULO      = 60,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             slow_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [7:0]       load_val_i,
    output logic             tick_o,
    output logic [BCD_W-1:0] units_o,
    output logic [BCD_W-1:0] tens_o,
    output logic             wrap_o,
    output logic [SEG_W-1:0] seg_units_o,
    output logic [SEG_W-1:0] seg_tens_o
);

    localparam logic [BCD_W-1:0] MAX_TENS  = BCD_W'((MODULO - 1) / 10);
    localparam logic [BCD_W-1:0] MAX_UNITS = BCD_W'((MODULO - 1) % 10);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_tick;
    logic                   r_wrap;
    logic [BCD_W-1:0]       r_units;
    logic [BCD_W-1:0]       r_tens;

    logic                   w_sync_out;
    logic                   w_at_max;
    logic                   w_at_zero;
    logic [7:0]             w_load_bin;
    logic                   w_load_ok;
    bcd_step_t              w_units_step;
    logic [BCD_W-1:0]       w_next_units;
    logic [BCD_W-1:0]       w_next_tens;
    logic                   w_next_wrap;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_at_max   = (r_tens == MAX_TENS) && (r_units == MAX_UNITS);
    assign w_at_zero  = (r_tens == '0) && (r_units == '0);
    assign w_load_bin = 8'(load_val_i[7:4]) * 8'd10 + 8'(load_val_i[3:0]);
    assign w_load_ok  = (load_val_i[7:4] <= 4'd9) && (load_val_i[3:0] <= 4'd9)
                        && (32'(w_load_bin) < MODULO);

    // Next count for a tick; the modulus endpoints wrap explicitly
    always_comb begin
        w_next_units = r_units;
        w_next_tens  = r_tens;
        w_next_wrap  = 1'b0;
        w_units_step = bcd_step(r_units, up_i);
        if (up_i) begin
            if (w_at_max) begin
                w_next_units = '0;
                w_next_tens  = '0;
                w_next_wrap  = 1'b1;
            end else begin
                w_next_units = w_units_step.digit;
                if (w_units_step.carry) w_next_tens = r_tens + BCD_W'(1);
            end
        end else begin
            if (w_at_zero) begin
                w_next_units = MAX_UNITS;
                w_next_tens  = MAX_TENS;
                w_next_wrap  = 1'b1;
            end else begin
                w_next_units = w_units_step.digit;
                if (w_units_step.carry) w_next_tens = r_tens - BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_units <= '0;
            r_tens  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], slow_i};
            r_prev <= w_sync_out;
            r_tick <= w_sync_out & ~r_prev;
            r_wrap <= 1'b0;
            // A load swallows any coincident tick
            if (load_i) begin
                r_units <= w_load_ok ? load_val_i[3:0] : '0;
                r_tens  <= w_load_ok ? load_val_i[7:4] : '0;
            end else if (r_tick && en_i) begin
                r_units <= w_next_units;
                r_tens  <= w_next_tens;
                r_wrap  <= w_next_wrap;
            end
        end
    end

    assign tick_o  = r_tick;
    assign wrap_o  = r_wrap;
    assign units_o = r_units;
    assign tens_o  = r_tens;

    seg7_decode u_seg_units (
        .i_digit (r_units),
        .o_seg_c (seg_units_o)
    );

    seg7_decode u_seg_tens (
        .i_digit (r_tens),
        .o_seg_c (seg_tens_o)
    );

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
Downstream consumer of the frequency divider's slow square-wave output (clk_div, nominally 1 Hz toggle-rate from the 50 MHz board clock). It resynchronises the slow signal into the system clock domain and converts each rising edge into a one-cycle tick. The tick drives a two-digit BCD modulo counter (up/down, enable, parallel load). The counter value is decoded to two active-low seven-segment outputs for the board display.

Parameters:
MODULO, 60, count modulus; legal range 2..100; the count runs 0..MODULO-1.
SYNC_STAGES, 2, number of synchroniser flops on slow_i; minimum 2.

Ports:
clk_i  input  1  system clock (50 MHz); the only clock.
rst_i  input  1  synchronous reset, active-high.
slow_i  input  1  divided square wave from the frequency divider; treated as asynchronous.
en_i  input  1  count enable; 1 = count on tick.
up_i  input  1  direction; 1 = up, 0 = down; sampled on the tick cycle.
load_i  input  1  parallel-load strobe.
load_val_i  input  8  BCD load value {tens[7:4], units[3:0]}.
tick_o  output  1  one-cycle pulse per slow_i rising edge.
units_o  output  4  BCD units digit.
tens_o  output  4  BCD tens digit.
wrap_o  output  1  one-cycle pulse on wrap-around.
seg_units_o  output  7  active-low segments for units, bit order {g,f,e,d,c,b,a}.
seg_tens_o  output  7  active-low segments for tens, same bit order.

Behaviour:
- Reset: one clock, synchronous and active-high, with rst_i sampled on posedge clk_i. It clears the synchroniser chain, the edge-detect register, units_o, tens_o, tick_o and wrap_o to 0. seg_units_o and seg_tens_o then equal 7'b1000000 (digit "0").
- Reset has priority over every other input. Reset asserted mid-count clears everything on that same edge.
- Synchroniser: slow_i passes through SYNC_STAGES flops. An edge register holds the previous synchronised value.
- Tick generation: tick_o is registered and equals sync_out & ~prev.
  - Latency: a slow_i rise seen at edge k gives tick_o = 1 during cycle k+SYNC_STAGES.
  - Falling edges produce no tick.
  - If slow_i is already 1 when reset releases, exactly one tick is produced once the chain fills.
- Counter update: the counter updates on the clock edge where tick_o = 1 or load_i = 1. The new value is visible on the next cycle.
- Priority: rst_i > load_i > (tick_o & en_i). A load coinciding with a tick wins, and that tick is discarded.
- Load validity: a load is valid only if both nibbles are <= 9 and the value 10*tens+units < MODULO. An invalid load sets the count to 00. A load never asserts wrap_o.
- Counting up: units increments. At units 9 it becomes 0 and tens increments. At count MODULO-1 the next tick gives 00 and wrap_o pulses.
- Counting down: at units 0 the units digit becomes 9 and tens decrements. At count 00 the next tick gives MODULO-1 in BCD and wrap_o pulses.
- wrap_o: registered; high for exactly the cycle after the wrapping update, i.e. aligned with the new count.
- en_i = 0: tick_o is still generated, the count holds, and wrap_o stays 0.
- Direction change: up_i may change at any time. Only its value on the tick cycle matters.
- Digit range: tens is always <= (MODULO-1)/10, and each digit is always <= 9. Non-BCD digit codes (should be unreachable) decode to all segments off (7'b1111111).
- Segment decode: combinational from the registered digits, with no extra latency.

Decomposition:
- A shared package holds:
  - the seven-segment constant table for 0..9 and blank (SEG_0..SEG_9, SEG_OFF);
  - the BCD digit width constant (4);
  - a helper function for BCD increment/decrement with carry/borrow.
- One sub-module is natural: seg7_decode, the 4-bit BCD to 7-bit active-low decoder, instantiated twice. It is reusable by other display blocks.
- The synchroniser and edge detector stay inline.

Test Plan:
- Reset and first edge: hold rst_i for 3 cycles with slow_i = 0, release, then raise slow_i at cycle 10. Required: tick_o = 1 only at cycle 12 (SYNC_STAGES = 2); count goes to 01; seg_units_o changes 7'b1000000 -> 7'b1111001.
- Up wrap: load 8'h58 with up_i = 1 and en_i = 1, then apply 2 slow_i rising edges. Required: count 59 then 00; wrap_o is a single pulse aligned with 00; tens_o = 0.
- Down wrap and borrow: load 8'h10, up_i = 0, apply 2 edges. Required: 10 -> 09 -> 08. Then load 8'h00 and apply 1 edge. Required: count 59 with a wrap_o pulse.
- Load versus tick collision: assert load_i with load_val_i = 8'h33 in the same cycle tick_o = 1. Required: count = 33 (not 34); wrap_o = 0. Then load 8'h7A and 8'h65. Required: count 00 after each.
- Enable and falling edges: en_i = 0 for 5 full slow_i periods. Required: 5 tick_o pulses (one per rise, none on falls); count is unchanged.
- Reset mid-count: with count = 42, assert rst_i for 1 cycle coincident with tick_o. Required: count = 00, tick_o = 0 and wrap_o = 0 on the next cycle; the following slow_i rise ticks normally.
